// File: rtl/bp_sched_pkg.sv
// rtl/bp_sched_pkg.sv - shared types and constants for the branch-predictor update scheduler
package bp_sched_pkg;

    localparam int INDEX_W_DEFAULT = 10;

    localparam int MASK_BST  = 0;
    localparam int MASK_PERC = 1;
    localparam int MASK_BF   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [INDEX_W_DEFAULT-1:0] index;
        logic                       taken;
        logic [2:0]                 mask;
    } upd_entry_t;

endpackage

// File: rtl/bp_update_fifo.sv
// rtl/bp_update_fifo.sv - synchronous FIFO holding resolved-branch update entries
module bp_update_fifo
    import bp_sched_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = upd_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  T                       din,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    cnt;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/bp_update_scheduler.sv
// rtl/bp_update_scheduler.sv - arbitrates the predictor table port between fetch lookups and RMW training updates
module bp_update_scheduler
    import bp_sched_pkg::*;
#(
    parameter int INDEX_W    = INDEX_W_DEFAULT,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   upd_valid,
    output logic                   upd_ready,
    input  logic [INDEX_W-1:0]     upd_index,
    input  logic                   upd_taken,
    input  logic [2:0]             upd_mask,
    input  logic                   lookup_req,
    output logic                   lookup_gnt,
    output logic                   tbl_rd_en,
    output logic                   tbl_wr_en,
    output logic [INDEX_W-1:0]     tbl_index,
    output logic                   tbl_wr_taken,
    output logic [2:0]             tbl_wr_mask,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   busy
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic               taken;
        logic [2:0]         mask;
    } entry_t;

    sched_state_e          state;
    logic [SW-1:0]         starve_cnt;
    entry_t                din;
    entry_t                head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [$clog2(DEPTH):0] count;
    logic                  issue;
    logic                  starved;
    logic                  rd_q;
    logic                  wr_q;
    logic [INDEX_W-1:0]    index_q;
    logic                  taken_q;
    logic [2:0]            mask_q;

    assign din     = '{index: upd_index, taken: upd_taken, mask: upd_mask};
    assign push    = upd_valid && upd_ready;
    assign pop     = (state == WR);
    assign starved = (starve_cnt == SW'(STARVE_MAX));
    assign issue   = (state == IDLE) && !empty && !stall && (!lookup_req || full || starved);

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Head is stable from issue until the WR pop, so it is latched into the table outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            index_q    <= '0;
            taken_q    <= 1'b0;
            mask_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state      <= RD;
                        rd_q       <= 1'b1;
                        index_q    <= head.index;
                        starve_cnt <= '0;
                    end else if (empty) begin
                        starve_cnt <= '0;
                    end else if (!stall && !starved) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                RD: begin
                    state             <= WR;
                    rd_q              <= 1'b0;
                    wr_q              <= 1'b1;
                    taken_q           <= head.taken;
                    mask_q[MASK_BST]  <= head.mask[MASK_BST];
                    mask_q[MASK_PERC] <= head.mask[MASK_PERC];
                    mask_q[MASK_BF]   <= head.mask[MASK_BF];
                end
                default: begin
                    state   <= IDLE;
                    wr_q    <= 1'b0;
                    index_q <= '0;
                    taken_q <= 1'b0;
                    mask_q  <= '0;
                end
            endcase
        end
    end

    // Everything is forced low while rst is high, even before the first reset edge lands.
    assign upd_ready    = !rst && !full;
    assign lookup_gnt   = !rst && (state == IDLE) && lookup_req && !issue;
    assign tbl_rd_en    = !rst && rd_q;
    assign tbl_wr_en    = !rst && wr_q;
    assign tbl_index    = rst ? '0 : index_q;
    assign tbl_wr_taken = !rst && taken_q;
    assign tbl_wr_mask  = rst ? '0 : mask_q;
    assign q_count      = rst ? '0 : count;
    assign busy         = !rst && (state != IDLE);

endmodule

// File: tb/tb_bp_update_scheduler.sv
// tb/tb_bp_update_scheduler.sv - scoreboard bench for bp_update_scheduler
module tb_bp_update_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [9:0] upd_index = '0;
    logic       upd_taken = 1'b0;
    logic [2:0] upd_mask = '0;
    logic       lookup_req = 1'b0;
    logic       lookup_gnt;
    logic       tbl_rd_en;
    logic       tbl_wr_en;
    logic [9:0] tbl_index;
    logic       tbl_wr_taken;
    logic [2:0] tbl_wr_mask;
    logic [2:0] q_count;
    logic       busy;

    typedef struct {
        logic [9:0] index;
        logic       taken;
        logic [2:0] mask;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    bp_update_scheduler #(
        .INDEX_W    (10),
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_index    (upd_index),
        .upd_taken    (upd_taken),
        .upd_mask     (upd_mask),
        .lookup_req   (lookup_req),
        .lookup_gnt   (lookup_gnt),
        .tbl_rd_en    (tbl_rd_en),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_index    (tbl_index),
        .tbl_wr_taken (tbl_wr_taken),
        .tbl_wr_mask  (tbl_wr_mask),
        .q_count      (q_count),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] i, input logic t, input logic [2:0] m);
        int   n = 0;
        exp_t e;
        upd_valid = 1'b1;
        upd_index = i;
        upd_taken = t;
        upd_mask  = m;
        while (!upd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!upd_ready) begin
            chk("push_timeout", 32'(upd_ready), 32'd1);
        end else begin
            e.index = i;
            e.taken = t;
            e.mask  = m;
            exp_q.push_back(e);
        end
        tick();
        upd_valid = 1'b0;
    endtask

    // Monitor: every table access is checked against the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (tbl_rd_en) begin
                if (exp_q.size() == 0) chk("rd_unexpected", 32'(tbl_rd_en), 32'd0);
                else chk("rd_index", 32'(tbl_index), 32'(exp_q[0].index));
            end
            if (tbl_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 32'(tbl_wr_en), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_index", 32'(tbl_index), 32'(e.index));
                    chk("wr_taken", 32'(tbl_wr_taken), 32'(e.taken));
                    chk("wr_mask", 32'(tbl_wr_mask), 32'(e.mask));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        // 1. reset with upd_valid held high
        rst = 1'b1;
        upd_valid = 1'b1;
        tick();
        tick();
        chk("rst_upd_ready", 32'(upd_ready), 32'd0);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_rd_en", 32'(tbl_rd_en), 32'd0);
        chk("rst_wr_en", 32'(tbl_wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        upd_valid = 1'b0;
        #1;
        chk("post_rst_upd_ready", 32'(upd_ready), 32'd1);
        chk("post_rst_q_count", 32'(q_count), 32'd0);

        // 2. single update, fetch idle
        lookup_req = 1'b0;
        push(10'h005, 1'b1, 3'b011);
        chk("t2_idle_after_push", 32'(busy), 32'd0);
        chk("t2_q_count_push", 32'(q_count), 32'd1);
        tick();
        chk("t2_rd_en", 32'(tbl_rd_en), 32'd1);
        chk("t2_rd_index", 32'(tbl_index), 32'h005);
        tick();
        chk("t2_wr_en", 32'(tbl_wr_en), 32'd1);
        chk("t2_wr_mask", 32'(tbl_wr_mask), 32'b011);
        chk("t2_wr_taken", 32'(tbl_wr_taken), 32'd1);
        tick();
        chk("t2_q_count_done", 32'(q_count), 32'd0);
        chk("t2_idle_index", 32'(tbl_index), 32'd0);

        // 3. starvation override with continuous lookups
        lookup_req = 1'b1;
        push(10'h02A, 1'b0, 3'b100);
        for (int k = 0; k < 8; k++) begin
            chk("t3_gnt_before_starve", 32'(lookup_gnt), 32'd1);
            chk("t3_no_rd", 32'(tbl_rd_en), 32'd0);
            tick();
        end
        chk("t3_gnt_at_issue", 32'(lookup_gnt), 32'd0);
        tick();
        chk("t3_rd_en", 32'(tbl_rd_en), 32'd1);
        chk("t3_gnt_rd", 32'(lookup_gnt), 32'd0);
        tick();
        chk("t3_wr_en", 32'(tbl_wr_en), 32'd1);
        chk("t3_gnt_wr", 32'(lookup_gnt), 32'd0);
        tick();
        chk("t3_gnt_after", 32'(lookup_gnt), 32'd1);

        // 4. full FIFO forces issue ahead of lookups
        push(10'h101, 1'b1, 3'b001);
        push(10'h202, 1'b0, 3'b010);
        push(10'h303, 1'b1, 3'b100);
        push(10'h3FF, 1'b0, 3'b000);
        chk("t4_full_ready", 32'(upd_ready), 32'd0);
        chk("t4_full_count", 32'(q_count), 32'd4);
        chk("t4_full_gnt", 32'(lookup_gnt), 32'd0);
        upd_valid = 1'b1;
        upd_index = 10'h0C3;
        upd_taken = 1'b1;
        upd_mask  = 3'b111;
        tick();
        chk("t4_rd_en", 32'(tbl_rd_en), 32'd1);
        chk("t4_rd_ready", 32'(upd_ready), 32'd0);
        tick();
        chk("t4_wr_en", 32'(tbl_wr_en), 32'd1);
        chk("t4_wr_ready", 32'(upd_ready), 32'd0);
        tick();
        chk("t4_after_pop_count", 32'(q_count), 32'd3);
        chk("t4_after_pop_ready", 32'(upd_ready), 32'd1);
        begin
            exp_t e;
            e.index = 10'h0C3;
            e.taken = 1'b1;
            e.mask  = 3'b111;
            exp_q.push_back(e);
        end
        tick();
        upd_valid = 1'b0;
        chk("t4_fifth_count", 32'(q_count), 32'd4);
        lookup_req = 1'b0;
        n = 0;
        while ((q_count != 0 || busy) && n < 60) begin
            tick();
            n++;
        end
        chk("t4_drained", 32'(q_count), 32'd0);

        // 5. stall freezes the starvation counter and never cuts an RMW short
        lookup_req = 1'b1;
        push(10'h155, 1'b1, 3'b110);
        tick();
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_stall_idle", 32'(busy), 32'd0);
            chk("t5_stall_gnt", 32'(lookup_gnt), 32'd1);
            tick();
        end
        stall = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("t5_gnt_resume", 32'(lookup_gnt), 32'd1);
            tick();
        end
        chk("t5_gnt_issue", 32'(lookup_gnt), 32'd0);
        tick();
        chk("t5_rd_en", 32'(tbl_rd_en), 32'd1);
        stall = 1'b1;
        tick();
        chk("t5_wr_despite_stall", 32'(tbl_wr_en), 32'd1);
        stall = 1'b0;
        tick();
        chk("t5_idle", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 6. reset in the RD cycle aborts the update and discards the queue
        lookup_req = 1'b0;
        push(10'h2AA, 1'b0, 3'b101);
        push(10'h055, 1'b1, 3'b010);
        chk("t6_in_rd", 32'(tbl_rd_en), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_rd_low", 32'(tbl_rd_en), 32'd0);
        chk("t6_rst_ready_low", 32'(upd_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6_q_count", 32'(q_count), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_wr", 32'(tbl_wr_en), 32'd0);
            chk("t6_no_rd", 32'(tbl_rd_en), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
